// File: rtl/inner_vm.sv
// Byte-code inner interpreter: fetches opcodes from a byte-wide synchronous memory,
// pushes literals to the external data stack and nests CALL/EXIT on an internal return stack.
module inner_vm #(
    parameter int DSZ      = 8,
    parameter int ASZ      = 17,
    parameter int RS_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [ASZ-1:0] pfa,
    output logic           bsy,
    output logic           done,
    output logic           err,
    output logic [1:0]     err_code,
    output logic [ASZ-1:0] mem_a,
    input  logic [7:0]     mem_din,
    output logic           ds_push,
    output logic           ds_pop,
    output logic [DSZ-1:0] ds_dout,
    input  logic [DSZ-1:0] ds_tos,
    input  logic           ds_empty
);

    localparam int NA  = (ASZ + 7) / 8;
    localparam int RSW = $clog2(RS_DEPTH);
    localparam int CW  = (NA > 1) ? $clog2(NA) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_ARG    = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    localparam logic [7:0] OP_EXIT  = 8'h00;
    localparam logic [7:0] OP_LIT   = 8'h01;
    localparam logic [7:0] OP_BRAN  = 8'h02;
    localparam logic [7:0] OP_ZBRAN = 8'h03;
    localparam logic [7:0] OP_CALL  = 8'h04;
    localparam logic [7:0] OP_DUP   = 8'h05;
    localparam logic [7:0] OP_DROP  = 8'h06;
    localparam logic [7:0] OP_NOP   = 8'h07;

    localparam logic [1:0] ERR_ILLEGAL = 2'd0;
    localparam logic [1:0] ERR_RS_OVF  = 2'd1;
    localparam logic [1:0] ERR_DS_UNF  = 2'd2;

    logic [2:0]     st;
    logic [ASZ-1:0] ip;
    logic [RSW:0]   rsp;
    logic [7:0]     op;
    logic [CW-1:0]  cnt;
    logic [ASZ-1:0] tgt;
    logic [ASZ-1:0] rs [RS_DEPTH];

    logic signed [7:0] off8;
    logic [ASZ-1:0]    br_tgt;
    logic [ASZ-1:0]    tgt_next;
    logic [ASZ-1:0]    rs_top;
    logic [RSW-1:0]    rs_rd_idx;
    logic              last_byte;
    logic              rs_full;
    logic              call_push;

    // Branch offset is relative to the address just past the operand byte.
    assign off8      = mem_din;
    assign br_tgt    = ip + ASZ'(off8);
    assign tgt_next  = ASZ'({tgt, mem_din});
    assign rs_rd_idx = rsp[RSW-1:0] - RSW'(1);
    assign rs_top    = rs[rs_rd_idx];
    assign last_byte = (cnt == CW'(NA - 1));
    assign rs_full   = (rsp == (RSW+1)'(RS_DEPTH));
    assign call_push = (st == ST_ARG) && (op == OP_CALL) && last_byte && !rs_full;

    assign mem_a = ip;
    assign bsy   = (st == ST_FETCH) || (st == ST_DECODE) || (st == ST_ARG);
    assign err   = (st == ST_ERR);

    always_comb begin
        ds_push = 1'b0;
        ds_pop  = 1'b0;
        ds_dout = ds_tos;
        if (st == ST_DECODE) begin
            ds_push = (mem_din == OP_DUP)  && !ds_empty;
            ds_pop  = (mem_din == OP_DROP) && !ds_empty;
        end else if (st == ST_ARG) begin
            ds_dout = DSZ'(mem_din);
            ds_push = (op == OP_LIT);
            ds_pop  = (op == OP_ZBRAN) && !ds_empty;
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st       <= ST_IDLE;
            ip       <= '0;
            rsp      <= '0;
            op       <= '0;
            cnt      <= '0;
            tgt      <= '0;
            done     <= 1'b0;
            err_code <= ERR_ILLEGAL;
        end else begin
            done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (en) begin
                        ip <= pfa;
                        st <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ip <= ip + ASZ'(1);
                    st <= ST_DECODE;
                end
                ST_DECODE: begin
                    op <= mem_din;
                    case (mem_din)
                        OP_EXIT: begin
                            if (rsp == '0) begin
                                done <= 1'b1;
                                st   <= ST_IDLE;
                            end else begin
                                ip  <= rs_top;
                                rsp <= rsp - (RSW+1)'(1);
                                st  <= ST_FETCH;
                            end
                        end
                        OP_LIT, OP_BRAN, OP_ZBRAN, OP_CALL: begin
                            ip  <= ip + ASZ'(1);
                            cnt <= '0;
                            st  <= ST_ARG;
                        end
                        OP_DUP, OP_DROP: begin
                            if (ds_empty) begin
                                err_code <= ERR_DS_UNF;
                                st       <= ST_ERR;
                            end else begin
                                st <= ST_FETCH;
                            end
                        end
                        OP_NOP: st <= ST_FETCH;
                        default: begin
                            err_code <= ERR_ILLEGAL;
                            st       <= ST_ERR;
                        end
                    endcase
                end
                ST_ARG: begin
                    case (op)
                        OP_LIT: st <= ST_FETCH;
                        OP_BRAN: begin
                            ip <= br_tgt;
                            st <= ST_FETCH;
                        end
                        OP_ZBRAN: begin
                            if (ds_empty) begin
                                err_code <= ERR_DS_UNF;
                                st       <= ST_ERR;
                            end else begin
                                if (ds_tos == '0)
                                    ip <= br_tgt;
                                st <= ST_FETCH;
                            end
                        end
                        OP_CALL: begin
                            tgt <= tgt_next;
                            if (!last_byte) begin
                                ip  <= ip + ASZ'(1);
                                cnt <= cnt + CW'(1);
                            end else if (rs_full) begin
                                err_code <= ERR_RS_OVF;
                                st       <= ST_ERR;
                            end else begin
                                rsp <= rsp + (RSW+1)'(1);
                                ip  <= tgt_next;
                                st  <= ST_FETCH;
                            end
                        end
                        default: begin
                            err_code <= ERR_ILLEGAL;
                            st       <= ST_ERR;
                        end
                    endcase
                end
                ST_ERR: st <= ST_ERR;
                default: st <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the return stack is storage only; rsp==0 after reset makes its contents irrelevant, so it has no reset.
    always_ff @(posedge clk) begin
        if (rst && call_push)
            rs[rsp[RSW-1:0]] <= ip;
    end

endmodule

// File: tb/tb_inner_vm.sv
// Scoreboard bench for inner_vm: directed byte-code programs, expected stack/done/err
// events queued by the stimulus and compared by an independent monitor.
module tb_inner_vm;

    localparam int ASZ = 17;
    localparam int DSZ = 8;

    typedef enum logic [1:0] {EV_PUSH, EV_POP, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [15:0] val;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic [ASZ-1:0] pfa = '0;
    logic           bsy, done, err;
    logic [1:0]     err_code;
    logic [ASZ-1:0] mem_a;
    logic [7:0]     mem_din;
    logic           ds_push, ds_pop;
    logic [DSZ-1:0] ds_dout, ds_tos;
    logic           ds_empty;

    logic [7:0]     mem [0:(1<<ASZ)-1];
    logic [DSZ-1:0] stk [0:63];
    logic [5:0]     sp;
    logic           init_one = 1'b0;
    logic [DSZ-1:0] init_v   = '0;
    logic           err_q    = 1'b0;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    inner_vm #(.DSZ(DSZ), .ASZ(ASZ), .RS_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .pfa(pfa), .bsy(bsy), .done(done),
        .err(err), .err_code(err_code), .mem_a(mem_a), .mem_din(mem_din),
        .ds_push(ds_push), .ds_pop(ds_pop), .ds_dout(ds_dout),
        .ds_tos(ds_tos), .ds_empty(ds_empty)
    );

    // Synchronous byte memory: data for mem_a appears one cycle later.
    always @(posedge clk) mem_din <= mem[mem_a];

    // Data stack model; reset loads an optional single preset entry.
    always @(posedge clk) begin
        if (!rst) begin
            sp     <= init_one ? 6'd1 : 6'd0;
            stk[0] <= init_v;
        end else if (ds_push) begin
            stk[sp] <= ds_dout;
            sp      <= sp + 6'd1;
        end else if (ds_pop && sp != 6'd0) begin
            sp <= sp - 6'd1;
        end
    end
    assign ds_empty = (sp == 6'd0);
    assign ds_tos   = ds_empty ? '0 : stk[sp - 6'd1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic observe(input ev_kind_t kind, input logic [15:0] val);
        ev_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d val 0x%0h, expected none", kind, val);
        end else begin
            e = expq.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_val", 32'(val), 32'(e.val));
        end
    endtask

    always @(negedge clk) begin
        if (ds_push && ds_pop)
            check("push_pop_exclusive", 32'(ds_pop), 32'd0);
        if (ds_push) observe(EV_PUSH, 16'(ds_dout));
        if (ds_pop)  observe(EV_POP, 16'(ds_tos));
        if (done)    observe(EV_DONE, 16'd0);
        if (err === 1'b1 && err_q !== 1'b1) observe(EV_ERR, 16'(err_code));
        err_q = err;
    end

    task automatic expect_ev(input ev_kind_t kind, input logic [15:0] val);
        expq.push_back('{kind: kind, val: val});
    endtask

    task automatic do_reset(input logic one, input logic [DSZ-1:0] v);
        @(negedge clk);
        rst      = 1'b0;
        init_one = one;
        init_v   = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start(input logic [ASZ-1:0] addr);
        @(negedge clk);
        en  = 1'b1;
        pfa = addr;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done || err) break;
            if (lat >= budget) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no done/err after %0d cycles, expected one", lat);
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        repeat (2) @(negedge clk);
        check(name, 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    initial begin
        int lat;
        int ovf_lat;
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'hFF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bsy", 32'(bsy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_strobes", 32'({ds_push, ds_pop}), 32'd0);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        rst = 1'b1;

        // LIT 0x2A; EXIT -> done 5 cycles after the en edge
        mem[17'h100] = 8'h01; mem[17'h101] = 8'h2A; mem[17'h102] = 8'h00;
        expect_ev(EV_PUSH, 16'h2A);
        expect_ev(EV_DONE, 16'd0);
        start(17'h100);
        wait_end(50, lat);
        check("lit_latency", 32'(lat), 32'd5);
        drain("lit_drained");
        // Bare top-level EXIT: rsp must be 0, so done after 2 cycles
        expect_ev(EV_DONE, 16'd0);
        start(17'h102);
        wait_end(50, lat);
        check("exit_latency", 32'(lat), 32'd2);
        drain("exit_drained");

        // CALL 0x000200; callee LIT 7, EXIT; return to EXIT at 0x104
        mem[17'h100] = 8'h04; mem[17'h101] = 8'h00; mem[17'h102] = 8'h02;
        mem[17'h103] = 8'h00; mem[17'h104] = 8'h00;
        mem[17'h200] = 8'h01; mem[17'h201] = 8'h07; mem[17'h202] = 8'h00;
        expect_ev(EV_PUSH, 16'h07);
        expect_ev(EV_DONE, 16'd0);
        start(17'h100);
        wait_end(80, lat);
        check("call_latency", 32'(lat), 32'd12);
        drain("call_drained");

        // 0BRAN taken (tos=0, off=-2) loops to itself, then underflows on the second pass
        mem[17'h300] = 8'h03; mem[17'h301] = 8'hFE;
        do_reset(1'b1, 8'h00);
        expect_ev(EV_POP, 16'h00);
        expect_ev(EV_ERR, 16'd2);
        start(17'h300);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("zbran_taken_ip", 32'(mem_a), 32'h300);
        wait_end(50, lat);
        drain("zbran0_drained");

        // 0BRAN not taken (tos=5): falls through to EXIT at op+2
        mem[17'h310] = 8'h03; mem[17'h311] = 8'hFE; mem[17'h312] = 8'h00;
        do_reset(1'b1, 8'h05);
        expect_ev(EV_POP, 16'h05);
        expect_ev(EV_DONE, 16'd0);
        start(17'h310);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("zbran_fall_ip", 32'(mem_a), 32'h312);
        wait_end(50, lat);
        drain("zbran5_drained");

        // DUP, DROP, DROP, DROP on a one-entry stack -> underflow on the last DROP
        mem[17'h600] = 8'h05; mem[17'h601] = 8'h06; mem[17'h602] = 8'h06; mem[17'h603] = 8'h06;
        do_reset(1'b1, 8'h55);
        expect_ev(EV_PUSH, 16'h55);
        expect_ev(EV_POP, 16'h55);
        expect_ev(EV_POP, 16'h55);
        expect_ev(EV_ERR, 16'd2);
        start(17'h600);
        wait_end(50, lat);
        drain("dupdrop_drained");

        // BRAN -3 from 0 wraps to the top address; LIT there reads its operand from 0
        mem[17'h00000] = 8'h02; mem[17'h00001] = 8'hFD; mem[17'h1FFFF] = 8'h01;
        do_reset(1'b0, 8'h00);
        expect_ev(EV_PUSH, 16'h02);
        expect_ev(EV_ERR, 16'd0);
        start(17'h00000);
        wait_end(50, lat);
        drain("wrap_drained");

        // Illegal opcode 0x3C
        mem[17'h700] = 8'h3C;
        do_reset(1'b0, 8'h00);
        expect_ev(EV_ERR, 16'd0);
        start(17'h700);
        wait_end(20, lat);
        check("illegal_latency", 32'(lat), 32'd2);
        drain("illegal_drained");

        // Self-calling CALL 0x000400: 16 calls fit, the 17th overflows
        mem[17'h400] = 8'h04; mem[17'h401] = 8'h00; mem[17'h402] = 8'h04; mem[17'h403] = 8'h00;
        do_reset(1'b0, 8'h00);
        expect_ev(EV_ERR, 16'd1);
        start(17'h400);
        wait_end(200, ovf_lat);
        check("ovf_latency", 32'(ovf_lat), 32'd85);
        check("ovf_err_code", 32'(err_code), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_mem_a_frozen", 32'(mem_a), 32'h404);
            check("ovf_bsy", 32'(bsy), 32'd0);
            @(negedge clk);
        end
        drain("ovf_drained");

        // Reset in the ARG phase of the third nested CALL, then a fresh top-level EXIT
        mem[17'h800] = 8'h00;
        do_reset(1'b0, 8'h00);
        start(17'h400);
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("midcall_bsy", 32'(bsy), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_bsy", 32'(bsy), 32'd0);
        check("midrst_flags", 32'({done, err, ds_push, ds_pop}), 32'd0);
        check("midrst_mem_a", 32'(mem_a), 32'd0);
        rst = 1'b1;
        expect_ev(EV_DONE, 16'd0);
        start(17'h800);
        wait_end(50, lat);
        check("midrst_exit_latency", 32'(lat), 32'd2);
        drain("midrst_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
